// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX branch flush, MDU issue/busy sequencing.
// Outputs are combinational from state, cnt and inputs; MDU result is valid MDU_LAT cycles after mdu_go.
// Holds IF/ID/EX while the MDU iterates; optional perf counters when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rf_re0_id,
    input  logic        rf_re1_id,
    input  logic [4:0]  rf_ra0_id,
    input  logic [4:0]  rf_ra1_id,
    input  logic        rf_we_ex,
    input  logic [4:0]  rf_wa_ex,
    input  logic        mem_rd_ex,
    input  logic        br_taken_ex,
    input  logic        mdu_ex,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic        mdu_go,
    output logic        mdu_done,
    output logic        mdu_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Countdown start value; cnt==0 in BUSY is the release cycle.
    localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       load_use;

    // Load-use match: EX load writes a non-zero register that ID reads.
    always_comb begin
        load_use = mem_rd_ex && rf_we_ex && (rf_wa_ex != 5'd0) &&
                   ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
                    (rf_re1_id && (rf_ra1_id == rf_wa_ex)));
    end

    // Stall/flush decode; everything is forced low while reset is asserted.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        mdu_go    = 1'b0;
        mdu_done  = 1'b0;
        mdu_busy  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (br_taken_ex) begin
                        // ID holds a wrong-path instruction, so the branch wins over load-use.
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (mdu_ex) begin
                        mdu_go    = 1'b1;
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                    end else if (load_use) begin
                        // One bubble; next cycle the load is in MEM and forwarding covers it.
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                BUSY: begin
                    // mdu_ex/br_taken_ex are from the held mul/div and are ignored here.
                    mdu_busy = 1'b1;
                    if (cnt != 4'd0) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                    end else begin
                        mdu_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // MDU sequencing FSM: issue from IDLE, count down in BUSY, release at cnt==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!br_taken_ex && mdu_ex) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Performance counters: stalled fetch cycles and IDLE-state branch redirects, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall_if) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if ((state == IDLE) && br_taken_ex) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table vectors for the IDLE decode,
// hand sequences for MDU timing, back-to-back issue, reset in BUSY and perf counters.
// Inputs change 1ns after posedge; outputs are compared at negedge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rf_re0_id, rf_re1_id, rf_we_ex, mem_rd_ex, br_taken_ex, mdu_ex;
    logic [4:0] rf_ra0_id, rf_ra1_id, rf_wa_ex;

    logic a_sif, a_sid, a_sex, a_fid, a_fex, a_fmem, a_go, a_done, a_busy;
    logic b_sif, b_sid, b_sex, b_fid, b_fex, b_fmem, b_go, b_done, b_busy;
    logic [8:0] o4, o1;

`ifdef HAZARD_PERF_EN
    logic [31:0] a_pstall, a_pflush, b_pstall, b_pflush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Output bundles: {stall_if,stall_id,stall_ex,flush_id,flush_ex,flush_mem,mdu_go,mdu_done,mdu_busy}
    assign o4 = {a_sif, a_sid, a_sex, a_fid, a_fex, a_fmem, a_go, a_done, a_busy};
    assign o1 = {b_sif, b_sid, b_sex, b_fid, b_fex, b_fmem, b_go, b_done, b_busy};

    hazard_ctrl #(.MDU_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .rf_re0_id(rf_re0_id), .rf_re1_id(rf_re1_id),
        .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id),
        .rf_we_ex(rf_we_ex), .rf_wa_ex(rf_wa_ex), .mem_rd_ex(mem_rd_ex),
        .br_taken_ex(br_taken_ex), .mdu_ex(mdu_ex),
        .stall_if(a_sif), .stall_id(a_sid), .stall_ex(a_sex),
        .flush_id(a_fid), .flush_ex(a_fex), .flush_mem(a_fmem),
        .mdu_go(a_go), .mdu_done(a_done), .mdu_busy(a_busy)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(a_pstall), .perf_flush_cnt(a_pflush)
`endif
    );

    hazard_ctrl #(.MDU_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .rf_re0_id(rf_re0_id), .rf_re1_id(rf_re1_id),
        .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id),
        .rf_we_ex(rf_we_ex), .rf_wa_ex(rf_wa_ex), .mem_rd_ex(mem_rd_ex),
        .br_taken_ex(br_taken_ex), .mdu_ex(mdu_ex),
        .stall_if(b_sif), .stall_id(b_sid), .stall_ex(b_sex),
        .flush_id(b_fid), .flush_ex(b_fex), .flush_mem(b_fmem),
        .mdu_go(b_go), .mdu_done(b_done), .mdu_busy(b_busy)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(b_pstall), .perf_flush_cnt(b_pflush)
`endif
    );

    typedef struct {
        string      name;
        logic       re0, re1;
        logic [4:0] ra0, ra1;
        logic       we;
        logic [4:0] wa;
        logic       mrd, br, mdu;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic re0, logic [4:0] ra0, logic re1, logic [4:0] ra1,
                                logic we, logic [4:0] wa, logic mrd, logic br, logic mdu,
                                logic [8:0] exp);
        vec_t v;
        v.name = name; v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
        v.we = we; v.wa = wa; v.mrd = mrd; v.br = br; v.mdu = mdu; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic set_in(logic re0, logic [4:0] ra0, logic re1, logic [4:0] ra1,
                          logic we, logic [4:0] wa, logic mrd, logic br, logic mdu);
        rf_re0_id = re0; rf_ra0_id = ra0; rf_re1_id = re1; rf_ra1_id = ra1;
        rf_we_ex = we; rf_wa_ex = wa; mem_rd_ex = mrd; br_taken_ex = br; mdu_ex = mdu;
    endtask

    // Advance to the next cycle's input window (1ns after posedge).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    localparam logic [8:0] ISSUE = 9'b111_001_100;
    localparam logic [8:0] HOLD  = 9'b111_001_001;
    localparam logic [8:0] DONE  = 9'b000_000_011;
    localparam logic [8:0] LU    = 9'b110_010_000;
    localparam logic [8:0] BR    = 9'b000_110_000;

    initial begin
        int  go_cnt;
        logic done_seen;

        // Reset: outputs low even with branch and mul/div requested.
        rst = 1'b1;
        set_in(1, 5, 1, 5, 1, 5, 1, 1, 1);
        @(negedge clk);
        check("reset_outs_lat4", 32'(o4), 32'd0);
        check("reset_outs_lat1", 32'(o1), 32'd0);
        next_cycle();
        do_reset();

        // MDU_LAT=4 with mdu_ex held: go only at cycle 0, stalls 0-3, done at 4.
        for (int c = 0; c < 6; c++) begin
            set_in(0, 0, 0, 0, 1, 3, 0, 0, (c < 5) ? 1'b1 : 1'b0);
            @(negedge clk);
            case (c)
                0:       check("mdu4_c0_issue", 32'(o4), 32'(ISSUE));
                1, 2, 3: check($sformatf("mdu4_c%0d_hold", c), 32'(o4), 32'(HOLD));
                4:       check("mdu4_c4_done", 32'(o4), 32'(DONE));
                default: check("mdu4_c5_idle", 32'(o4), 32'd0);
            endcase
            next_cycle();
        end

`ifdef HAZARD_PERF_EN
        // One taken branch after the mul/div, then counter readback and clear.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("perf_stall_cnt", a_pstall, 32'd4);
        check("perf_flush_cnt", a_pflush, 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("perf_stall_clr", a_pstall, 32'd0);
        check("perf_flush_clr", a_pflush, 32'd0);
        next_cycle();
`endif

        // Back-to-back mul/div on the MDU_LAT=1 instance.
        do_reset();
        go_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            set_in(0, 0, 0, 0, 1, 3, 0, 0, (c < 4) ? 1'b1 : 1'b0);
            @(negedge clk);
            if (b_go) go_cnt++;
            case (c)
                0, 2:    check($sformatf("b2b_c%0d_issue", c), 32'(o1), 32'(ISSUE));
                1, 3:    check($sformatf("b2b_c%0d_done", c), 32'(o1), 32'(DONE));
                default: check("b2b_c4_idle", 32'(o1), 32'd0);
            endcase
            next_cycle();
        end
        check("b2b_go_pulses", go_cnt, 32'd2);

        // Reset in BUSY with cnt=2 on the MDU_LAT=4 instance.
        do_reset();
        done_seen = 1'b0;
        set_in(0, 0, 0, 0, 1, 3, 0, 0, 1);
        @(negedge clk);
        check("rstbusy_issue", 32'(o4), 32'(ISSUE));
        next_cycle();
        @(negedge clk);
        check("rstbusy_cnt3", 32'(o4), 32'(HOLD));
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rstbusy_during_rst", 32'(o4), 32'd0);
        next_cycle();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (a_done) done_seen = 1'b1;
            if (c == 0) check("rstbusy_after_rst", 32'(o4), 32'd0);
            next_cycle();
        end
        check("rstbusy_no_done", 32'(done_seen), 32'd0);

        // Table-driven IDLE decode.
        do_reset();
        //                    name             re0 ra0 re1 ra1 we wa mrd br mdu exp
        vecs.push_back(mk("lu_rs1",           1,  5,  0,  0,  1, 5, 1,  0, 0,  LU));
        vecs.push_back(mk("lu_wa0_rs1_5",     1,  5,  0,  0,  1, 0, 1,  0, 0,  9'd0));
        vecs.push_back(mk("lu_x0_match",      1,  0,  1,  0,  1, 0, 1,  0, 0,  9'd0));
        vecs.push_back(mk("lu_rs2",           0,  0,  1,  7,  1, 7, 1,  0, 0,  LU));
        vecs.push_back(mk("lu_rs2_noread",    0,  0,  0,  7,  1, 7, 1,  0, 0,  9'd0));
        vecs.push_back(mk("lu_rs1_noread",    0,  5,  1,  3,  1, 5, 1,  0, 0,  9'd0));
        vecs.push_back(mk("alu_no_load",      1,  5,  1,  5,  1, 5, 0,  0, 0,  9'd0));
        vecs.push_back(mk("load_no_we",       1,  5,  1,  5,  0, 5, 1,  0, 0,  9'd0));
        vecs.push_back(mk("addr_mismatch",    1,  6,  1,  4,  1, 5, 1,  0, 0,  9'd0));
        vecs.push_back(mk("br_over_lu",       1,  5,  0,  0,  1, 5, 1,  1, 0,  BR));
        vecs.push_back(mk("br_over_mdu",      0,  0,  0,  0,  0, 0, 0,  1, 1,  BR));
        vecs.push_back(mk("idle_after_br",    0,  0,  0,  0,  0, 0, 0,  0, 0,  9'd0));
        foreach (vecs[i]) begin
            set_in(vecs[i].re0, vecs[i].ra0, vecs[i].re1, vecs[i].ra1,
                   vecs[i].we, vecs[i].wa, vecs[i].mrd, vecs[i].br, vecs[i].mdu);
            @(negedge clk);
            check(vecs[i].name, 32'(o4), 32'(vecs[i].exp));
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). It works alongside the EX-stage forwarding unit.
- Generates the stall and flush controls for three hazard types:
  - load-use hazards, which forwarding cannot cover;
  - branch/jump redirects resolved in EX;
  - the iterative multiply/divide unit (MDU).
- Owns the MDU issue/busy sequencing: a start pulse plus a fixed-latency countdown. EX is held until the result is ready, and bubbles are injected into EX/MEM.

Parameters:
- MDU_LAT, 4, MDU latency in cycles from mdu_go to result valid; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- rf_re0_id  in  1  ID instruction reads rs1
- rf_re1_id  in  1  ID instruction reads rs2
- rf_ra0_id  in  5  ID rs1 address
- rf_ra1_id  in  5  ID rs2 address
- rf_we_ex  in  1  EX instruction writes the register file
- rf_wa_ex  in  5  EX destination register
- mem_rd_ex  in  1  EX instruction is a load
- br_taken_ex  in  1  EX redirect (taken branch or jump)
- mdu_ex  in  1  EX instruction is a mul/div
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX register
- flush_id  out  1  clear IF/ID to a bubble
- flush_ex  out  1  clear ID/EX to a bubble
- flush_mem  out  1  clear EX/MEM to a bubble
- mdu_go  out  1  one-cycle MDU start pulse
- mdu_done  out  1  MDU result valid this cycle; EX/MEM latches it
- mdu_busy  out  1  FSM not in IDLE

Behaviour:

Clocking and reset:
- One clock; reset is synchronous and active-high (clk, rst).
- State update while rst=1: state <= IDLE, cnt <= 0.
- Outputs while rst=1: every output is forced to 0.

State:
- FSM has two states, IDLE and BUSY.
- cnt is a 4-bit down-counter.

Priority in IDLE (highest first):
1. Branch redirect, br_taken_ex=1:
   - flush_id=1, flush_ex=1; no stalls; state stays IDLE.
   - The branch overrides load-use, because the ID instruction is on the wrong path.
2. MDU issue, mdu_ex=1:
   - mdu_go=1; stall_if=stall_id=stall_ex=1; flush_mem=1.
   - Next state BUSY, cnt <= MDU_LAT-1.
3. Load-use hazard, detected when all of the following hold:
   - mem_rd_ex=1, rf_we_ex=1, rf_wa_ex!=0;
   - (rf_re0_id=1 and rf_ra0_id==rf_wa_ex) or (rf_re1_id=1 and rf_ra1_id==rf_wa_ex).
   - Response: stall_if=1, stall_id=1, flush_ex=1, for exactly one cycle.
   - The next cycle the load sits in MEM and the forwarding unit covers the dependency.
4. Otherwise all outputs are 0.

BUSY state:
- mdu_busy=1.
- While cnt!=0:
  - stall_if=stall_id=stall_ex=1, flush_mem=1;
  - cnt decrements each cycle.
- When cnt==0:
  - mdu_done=1; all stalls and flush_mem are 0, so the pipeline advances and EX/MEM latches the MDU result;
  - next state IDLE.
- mdu_ex and br_taken_ex are ignored in BUSY. The held EX instruction keeps mdu_ex asserted, and this must not retrigger an issue.
- Load-use detection is suppressed in BUSY, because EX holds a mul/div, not a load.

Timing:
- Total stall cycles per mul/div = MDU_LAT.
- EX occupancy = MDU_LAT+1 cycles.
- MDU_LAT=1: the issue cycle is followed immediately by the cnt==0 release.
- Back-to-back mul/div: the second instruction enters EX the cycle after release. It is seen in IDLE and issues normally; there is no gap beyond the pipeline advance.

Reset mid-operation:
- rst in BUSY returns the FSM to IDLE and drops all stalls the same edge.
- No mdu_done is emitted. The MDU itself is reset by the same rst.

Register x0 never causes a load-use stall.

Outputs are combinational from state, cnt and inputs. There are no registered output delays.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined — adds two performance-counter output ports:
  - perf_stall_cnt, out, 32 bits: increments on every cycle with stall_if=1.
  - perf_flush_cnt, out, 32 bits: increments on every cycle with br_taken_ex=1 in IDLE.
  - Both counters wrap modulo 2^32 and are cleared by rst.
- Not defined — the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
1. Load-use: EX = load to x5 (mem_rd_ex=1, rf_we_ex=1, rf_wa_ex=5); ID reads rs1=x5 with rf_re0_id=1 -> stall_if=stall_id=flush_ex=1 for one cycle. Same stimulus with rf_wa_ex=0 -> no stall.
2. Branch over load-use: br_taken_ex=1 together with a load-use match -> flush_id=flush_ex=1, stall_if=0.
3. MDU with MDU_LAT=4: mdu_ex held high from cycle 0 -> mdu_go=1 at cycle 0 only; stall_ex=1 and flush_mem=1 in cycles 0-3; mdu_done=1 with stalls=0 at cycle 4; IDLE at cycle 5.
4. Back-to-back mul/div with MDU_LAT=1: each instruction gives mdu_go, one stall cycle, then mdu_done; exactly two mdu_go pulses total.
5. rst asserted in BUSY with cnt=2 -> the next cycle has mdu_busy=0 and all outputs 0, and mdu_done never pulses.
6. HAZARD_PERF_EN: test 3 followed by one taken branch -> perf_stall_cnt=4, perf_flush_cnt=1; rst clears both to 0.
